// File: rtl/reg_file_pkg.sv
// Shared constants and types for the checkpointed register file.
package reg_file_pkg;
    localparam int DW_DEFAULT = 8;
    localparam int PW_DEFAULT = 4;

    typedef logic [DW_DEFAULT-1:0] word_t;
    typedef logic [PW_DEFAULT-1:0] addr_t;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: bank mux, hard-wired zero register and
// write-to-read bypass, plus the matching busy-bit lookup.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int PW      = PW_DEFAULT,
    parameter bit ZERO_R0 = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input  logic [2**PW-1:0][DW-1:0] bank,
    input  logic [2**PW-1:0]         busy,
    input  logic [PW-1:0]            rd_addr,
    input  logic                     wr_en,
    input  logic [PW-1:0]            wr_addr,
    input  logic [DW-1:0]            dat_in,
    input  logic                     ckpt_restore,
    output logic [DW-1:0]            dat_out,
    output logic                     busy_out
);
    logic is_zero;
    logic fwd_hit;

    // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        is_zero  = ZERO_R0 && (rd_addr == '0);
        // A restore in flight overrides the write, so the write data must not be forwarded.
        fwd_hit  = BYPASS && wr_en && (wr_addr == rd_addr) && !ckpt_restore;
        dat_out  = bank[rd_addr];
        if (is_zero)
            dat_out = '0;
        else if (fwd_hit)
            dat_out = dat_in;
        busy_out = !is_zero && busy[rd_addr];
    end
endmodule

// File: rtl/reg_file_ckpt.sv
// 2-read / 1-write register file with a one-deep checkpoint shadow bank
// and a per-register busy scoreboard for multi-cycle producers.
module reg_file_ckpt
    import reg_file_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int PW      = PW_DEFAULT,
    parameter bit ZERO_R0 = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic [PW-1:0] rd_addrA,
    input  logic [PW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    input  logic          busy_set,
    input  logic [PW-1:0] busy_addr,
    output logic          busyA,
    output logic          busyB,
    input  logic          ckpt_save,
    input  logic          ckpt_restore,
    output logic          ckpt_valid
);
    localparam int DEPTH = 2**PW;

    logic [DEPTH-1:0][DW-1:0] live, live_nxt;
    logic [DEPTH-1:0][DW-1:0] shadow;
    logic [DEPTH-1:0]         busy, busy_nxt;
    logic                     restore_act;
    logic                     save_act;

    always_comb begin
        live_nxt    = live;
        busy_nxt    = busy;
        restore_act = ckpt_restore && ckpt_valid;
        save_act    = ckpt_save && !restore_act;
        if (restore_act) begin
            live_nxt = shadow;
            busy_nxt = '0;
        end else begin
            if (wr_en && !(ZERO_R0 && wr_addr == '0)) begin
                live_nxt[wr_addr] = dat_in;
                busy_nxt[wr_addr] = 1'b0;
            end
            // Applied after the write so a same-cycle set on the same register wins.
            if (busy_set && !(ZERO_R0 && busy_addr == '0))
                busy_nxt[busy_addr] = 1'b1;
        end
    end

    // NOTE: the banks are architecturally cleared by reset, so they are flops with async reset, not RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live       <= '0;
            shadow     <= '0;
            busy       <= '0;
            ckpt_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            live <= live_nxt;
            busy <= busy_nxt;
            if (save_act) begin
                shadow     <= live_nxt;
                ckpt_valid <= 1'b1;
            end
        end
    end

    rf_read_port #(.DW(DW), .PW(PW), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)) u_port_a (
        .bank         (live),
        .busy         (busy),
        .rd_addr      (rd_addrA),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .dat_in       (dat_in),
        .ckpt_restore (ckpt_restore),
        .dat_out      (datA_out),
        .busy_out     (busyA)
    );

    rf_read_port #(.DW(DW), .PW(PW), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)) u_port_b (
        .bank         (live),
        .busy         (busy),
        .rd_addr      (rd_addrB),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .dat_in       (dat_in),
        .ckpt_restore (ckpt_restore),
        .dat_out      (datB_out),
        .busy_out     (busyB)
    );
endmodule

// File: tb/tb_reg_file_ckpt.sv
// Bench for reg_file_ckpt: two configurations driven in parallel, checked
// each cycle against an array-based model plus directed literal cases.
module tb_reg_file_ckpt;
    import reg_file_pkg::*;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    logic  wr_en, busy_set, ckpt_save, ckpt_restore;
    addr_t wr_addr, rd_addrA, rd_addrB, busy_addr;
    word_t dat_in;

    // Instance 0: ZERO_R0=0, BYPASS=1.  Instance 1: ZERO_R0=1, BYPASS=0.
    word_t a0, b0, a1, b1;
    logic  ba0, bb0, ba1, bb1, v0, v1;

    int n_checks = 0;
    int n_fail   = 0;

    word_t live_m   [2][16];
    word_t shadow_m [2][16];
    bit    busy_m   [2][16];
    bit    valid_m  [2];

    always #5 clk = ~clk;

    reg_file_ckpt #(.DW(8), .PW(4), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .datA_out(a0), .datB_out(b0),
        .busy_set(busy_set), .busy_addr(busy_addr), .busyA(ba0), .busyB(bb0),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .ckpt_valid(v0)
    );

    reg_file_ckpt #(.DW(8), .PW(4), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_z (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .datA_out(a1), .datB_out(b1),
        .busy_set(busy_set), .busy_addr(busy_addr), .busyA(ba1), .busyB(bb1),
        .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .ckpt_valid(v1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic word_t exp_dat(input int k, input addr_t a);
        if (k == 1 && a == 0) return '0;
        if (k == 0 && wr_en && wr_addr == a && !ckpt_restore) return dat_in;
        return live_m[k][a];
    endfunction

    function automatic bit exp_busy(input int k, input addr_t a);
        if (k == 1 && a == 0) return 1'b0;
        return busy_m[k][a];
    endfunction

    // Reference model: state evolves by the register-file rules on each edge.
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int r = 0; r < 16; r++) begin
                    live_m[k][r] = '0; shadow_m[k][r] = '0; busy_m[k][r] = 1'b0;
                end
                valid_m[k] = 1'b0;
            end else if (ckpt_restore && valid_m[k]) begin
                for (int r = 0; r < 16; r++) begin
                    live_m[k][r] = shadow_m[k][r]; busy_m[k][r] = 1'b0;
                end
            end else begin
                if (wr_en && !(k == 1 && wr_addr == 0)) begin
                    live_m[k][wr_addr] = dat_in;
                    busy_m[k][wr_addr] = 1'b0;
                end
                if (busy_set && !(k == 1 && busy_addr == 0))
                    busy_m[k][busy_addr] = 1'b1;
                if (ckpt_save) begin
                    for (int r = 0; r < 16; r++) shadow_m[k][r] = live_m[k][r];
                    valid_m[k] = 1'b1;
                end
            end
        end
    end

    // Compare process: outputs sampled mid-low-phase, after inputs settle.
    always @(negedge clk) begin
        #3;
        check("dut.datA",  a0,  exp_dat(0, rd_addrA));
        check("dut.datB",  b0,  exp_dat(0, rd_addrB));
        check("dut.busyA", ba0, exp_busy(0, rd_addrA));
        check("dut.busyB", bb0, exp_busy(0, rd_addrB));
        check("dut.valid", v0,  valid_m[0]);
        check("dutz.datA",  a1,  exp_dat(1, rd_addrA));
        check("dutz.datB",  b1,  exp_dat(1, rd_addrB));
        check("dutz.busyA", ba1, exp_busy(1, rd_addrA));
        check("dutz.busyB", bb1, exp_busy(1, rd_addrB));
        check("dutz.valid", v1,  valid_m[1]);
    end

    task automatic idle();
        wr_en = 0; wr_addr = 0; dat_in = 0; rd_addrA = 0; rd_addrB = 0;
        busy_set = 0; busy_addr = 0; ckpt_save = 0; ckpt_restore = 0;
    endtask

    task automatic next();
        @(negedge clk);
        idle();
    endtask

    task automatic probe();
        #4;
    endtask

    initial begin
        idle();
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state visible on every address.
        for (int i = 0; i < 16; i++) begin
            next(); rd_addrA = addr_t'(i); rd_addrB = addr_t'(15 - i); probe();
            check("rst.datA", a0, 8'h00);
            check("rst.datB", b1, 8'h00);
            check("rst.busyA", ba0, 1'b0);
            check("rst.valid", v0, 1'b0);
        end

        // Plain write then read.
        next(); wr_en = 1; wr_addr = 3; dat_in = 8'hA5;
        next(); rd_addrA = 3; probe();
        check("wr.r3", a0, 8'hA5);

        // Bypass present vs absent.
        next(); wr_en = 1; wr_addr = 5; dat_in = 8'h3C; rd_addrB = 5; probe();
        check("byp.on",  b0, 8'h3C);
        check("byp.off", b1, 8'h00);

        // Zero register.
        next(); wr_en = 1; wr_addr = 0; dat_in = 8'hFF; busy_set = 1; busy_addr = 0;
        next(); rd_addrA = 0; probe();
        check("r0.zero.dat",  a1, 8'h00);
        check("r0.zero.busy", ba1, 1'b0);
        check("r0.live.dat",  a0, 8'hFF);
        check("r0.live.busy", ba0, 1'b1);

        // Busy scoreboard.
        next(); busy_set = 1; busy_addr = 7;
        next(); rd_addrA = 7; probe();
        check("busy.set", ba0, 1'b1);
        wr_en = 1; wr_addr = 7; dat_in = 8'h11;
        next(); rd_addrA = 7; probe();
        check("busy.clr", ba0, 1'b0);
        check("busy.clr.dat", a1, 8'h11);
        next(); busy_set = 1; busy_addr = 7; wr_en = 1; wr_addr = 7; dat_in = 8'h22;
        next(); rd_addrA = 7; probe();
        check("busy.win", ba1, 1'b1);
        check("busy.win.dat", a1, 8'h22);

        // Checkpoint save / restore.
        next(); wr_en = 1; wr_addr = 2; dat_in = 8'h10;
        next(); ckpt_save = 1;
        next(); wr_en = 1; wr_addr = 2; dat_in = 8'h20;
        next(); rd_addrA = 2; probe();
        check("ck.pre", a0, 8'h20);
        ckpt_restore = 1;
        next(); rd_addrA = 2; rd_addrB = 7; probe();
        check("ck.r2", a0, 8'h10);
        check("ck.busy7", bb0, 1'b0);
        check("ck.valid", v1, 1'b1);
        next(); ckpt_restore = 1; wr_en = 1; wr_addr = 4; dat_in = 8'h99; rd_addrA = 4; probe();
        check("ck.nobyp", a0, 8'h00);
        next(); rd_addrA = 4; probe();
        check("ck.r4", a0, 8'h00);

        // Reset landing on a save cycle.
        next(); ckpt_save = 1; wr_en = 1; wr_addr = 9; dat_in = 8'h5A;
        #2 reset = 1'b1;
        next(); #1 reset = 1'b0; probe();
        check("rs.valid", v0, 1'b0);
        next(); ckpt_restore = 1; wr_en = 1; wr_addr = 6; dat_in = 8'h77;
        next(); rd_addrA = 6; rd_addrB = 2; probe();
        check("rs.nop.wr", a0, 8'h77);
        check("rs.nop.r2", b1, 8'h00);
        check("rs.nop.valid", v1, 1'b0);

        // Randomized traffic with collisions and occasional async reset.
        for (int n = 0; n < 3000; n++) begin
            next();
            wr_en        = ($urandom_range(0, 2) != 0);
            wr_addr      = addr_t'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15));
            dat_in       = word_t'($urandom);
            rd_addrA     = addr_t'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15));
            rd_addrB     = addr_t'($urandom_range(0, 15));
            busy_set     = ($urandom_range(0, 3) == 0);
            busy_addr    = addr_t'($urandom_range(0, 1) ? wr_addr : $urandom_range(0, 15));
            ckpt_save    = ($urandom_range(0, 15) == 0);
            ckpt_restore = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        next();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
